// File: rtl/uart_debug_loader.sv
// UART programming port: 8N1 byte receiver feeding a framed-command parser that
// streams payload bytes into imem/dmem over the debug write port and owns core reset.
module uart_debug_loader #(
  parameter int ClksPerBit  = 104,
  parameter int AddrWidth   = 13,
  parameter int TimeoutClks = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 debug_o,
  output logic [AddrWidth-1:0] debug_addr_o,
  output logic [7:0]           debug_data_o,
  output logic                 debug_imem_o,
  output logic                 mem_clear_o,
  output logic                 core_reset_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  localparam int CW = $clog2(ClksPerBit + 1);
  localparam int TW = $clog2(TimeoutClks + 1);
  localparam logic [CW-1:0] HALF = CW'(ClksPerBit / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(ClksPerBit - 1);
  localparam logic [TW-1:0] TLIM = TW'(TimeoutClks - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_e;
  typedef enum logic [2:0] {
    S_SYNC, S_CMD, S_ADDR_L, S_ADDR_H, S_LEN_L, S_LEN_H, S_DATA, S_CSUM
  } fsm_e;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_st_e        rx_st_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic          byte_vld_q, frm_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_st_q    <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_s1_q    <= rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      case (rx_st_q)
        RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_st_q  <= RX_START;
          rx_cnt_q <= '0;
        end
        RX_START: if (rx_cnt_q == HALF) begin
          rx_cnt_q <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? RX_IDLE : RX_DATA;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_DATA: if (rx_cnt_q == FULL) begin
          rx_cnt_q <= '0;
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        RX_STOP: if (rx_cnt_q == FULL) begin
          rx_cnt_q <= '0;
          rx_st_q  <= RX_IDLE;
          if (rx_s2_q) byte_vld_q <= 1'b1;
          else         frm_err_q  <= 1'b1;
        end else rx_cnt_q <= rx_cnt_q + CW'(1);
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  fsm_e                 st_q;
  logic [2:0]           cmd_q;
  logic [7:0]           lo_q, csum_q;
  logic [AddrWidth-1:0] wr_addr_q;
  logic [15:0]          len_q, idx_q;
  logic [TW-1:0]        idle_q;
  logic                 debug_q, imem_q, clr_q, core_q, done_q, err_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           data_q;
  logic [1:0]           code_q;

  logic [15:0] word16;
  logic        timeout;
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign word16  = {rx_sh_q, lo_q};
  assign timeout = (st_q != S_SYNC) && (idle_q == TLIM) && !byte_vld_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= S_SYNC;
      cmd_q     <= '0;
      lo_q      <= '0;
      csum_q    <= '0;
      wr_addr_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      idle_q    <= '0;
      debug_q   <= 1'b0;
      imem_q    <= 1'b0;
      clr_q     <= 1'b0;
      core_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      code_q    <= '0;
    end else begin
      debug_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      idle_q  <= (byte_vld_q || st_q == S_SYNC) ? '0 : idle_q + TW'(1);
      if (frm_err_q) begin
        err_q  <= 1'b1;
        code_q <= 2'd0;
      end
      if (timeout) begin
        err_q  <= 1'b1;
        code_q <= 2'd2;
        st_q   <= S_SYNC;
      end else if (byte_vld_q) begin
        csum_q <= csum_q ^ rx_sh_q;
        case (st_q)
          S_SYNC: if (rx_sh_q == 8'hA5) begin
            st_q   <= S_CMD;
            csum_q <= '0;
          end
          S_CMD: if (rx_sh_q >= 8'd1 && rx_sh_q <= 8'd5) begin
            cmd_q <= rx_sh_q[2:0];
            st_q  <= S_ADDR_L;
            if (rx_sh_q <= 8'd2) core_q <= 1'b1;
          end else begin
            err_q  <= 1'b1;
            code_q <= 2'd3;
            st_q   <= S_SYNC;
          end
          S_ADDR_L: begin
            lo_q <= rx_sh_q;
            st_q <= S_ADDR_H;
          end
          S_ADDR_H: begin
            wr_addr_q <= word16[AddrWidth-1:0];
            st_q      <= S_LEN_L;
          end
          S_LEN_L: begin
            lo_q <= rx_sh_q;
            st_q <= S_LEN_H;
          end
          S_LEN_H: begin
            len_q <= word16;
            idx_q <= '0;
            if (cmd_q >= 3'd3 && word16 != 16'd0) begin
              err_q  <= 1'b1;
              code_q <= 2'd3;
              st_q   <= S_SYNC;
            end else st_q <= (word16 == 16'd0) ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            debug_q   <= 1'b1;
            addr_q    <= wr_addr_q;
            data_q    <= rx_sh_q;
            imem_q    <= (cmd_q == 3'd1);
            wr_addr_q <= wr_addr_q + AddrWidth'(1);
            idx_q     <= idx_q + 16'd1;
            if (idx_q + 16'd1 == len_q) st_q <= S_CSUM;
          end
          S_CSUM: begin
            st_q <= S_SYNC;
            if (rx_sh_q == csum_q) begin
              done_q <= 1'b1;
              case (cmd_q)
                3'd3:    core_q <= 1'b0;
                3'd4:    core_q <= 1'b1;
                3'd5:    clr_q  <= 1'b1;
                default: ;
              endcase
            end else begin
              err_q  <= 1'b1;
              code_q <= 2'd1;
            end
          end
          default: st_q <= S_SYNC;
        endcase
      end
    end
  end

  assign debug_o      = debug_q;
  assign debug_addr_o = addr_q;
  assign debug_data_o = data_q;
  assign debug_imem_o = imem_q;
  assign mem_clear_o  = clr_q;
  assign core_reset_o = core_q;
  assign busy_o       = (st_q != S_SYNC);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;

endmodule

// File: tb/tb_uart_debug_loader.sv
// Randomized frame-level bench for uart_debug_loader: a whole-frame reference model
// predicts the write/done/err sequence and a per-cycle monitor checks the DUT against it.
module tb_uart_debug_loader;
  localparam int CPB = 4;
  localparam int AW  = 13;
  localparam int TO  = 200;

  logic          clk = 1'b0, reset = 1'b0, rx = 1'b1;
  logic          debug_o, debug_imem_o, mem_clear_o, core_reset_o, busy_o, done_o, err_o;
  logic [AW-1:0] debug_addr_o;
  logic [7:0]    debug_data_o;
  logic [1:0]    err_code_o;

  always #5 clk = ~clk;

  uart_debug_loader #(.ClksPerBit(CPB), .AddrWidth(AW), .TimeoutClks(TO)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .debug_o(debug_o), .debug_addr_o(debug_addr_o), .debug_data_o(debug_data_o),
    .debug_imem_o(debug_imem_o), .mem_clear_o(mem_clear_o), .core_reset_o(core_reset_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  int total = 0, bad = 0;
  logic [AW+8:0] wq[$], dlog[$];
  logic [4:0]    eq[$];
  logic [7:0]    tx[$], pay[$];
  int            n_send;
  bit            model_core = 1'b1;
  logic [AW+8:0] got_w, exp_w;
  logic [4:0]    got_e, exp_e;

  function automatic logic [4:0] ev(bit e, bit d, bit c, logic [1:0] code);
    return {e, d, c, code};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: every strobe/pulse must match the next model prediction, in order.
  always @(negedge clk) if (reset) begin
    if (debug_o) begin
      got_w = {debug_addr_o, debug_data_o, debug_imem_o};
      dlog.push_back(got_w);
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write got=%0h exp=none", got_w);
      end else begin
        exp_w = wq.pop_front();
        chk("write", got_w, exp_w);
      end
    end
    if (done_o || err_o || mem_clear_o) begin
      got_e = {err_o, done_o, mem_clear_o, err_o ? err_code_o : 2'b00};
      if (eq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event got=%0h exp=none", got_e);
      end else begin
        exp_e = eq.pop_front();
        chk("event", got_e, exp_e);
      end
    end
  end

  task automatic make_frame(input logic [7:0] cmd, input logic [15:0] base,
                            input logic [15:0] len, input bit corrupt);
    logic [7:0] cs;
    tx.delete();
    tx.push_back(8'hA5); tx.push_back(cmd);
    tx.push_back(base[7:0]); tx.push_back(base[15:8]);
    tx.push_back(len[7:0]); tx.push_back(len[15:8]);
    for (int i = 0; i < int'(len); i++)
      tx.push_back(i < pay.size() ? pay[i] : 8'($urandom));
    cs = 8'h00;
    for (int i = 1; i < tx.size(); i++) cs ^= tx[i];
    if (corrupt) cs ^= 8'($urandom_range(1, 255));
    tx.push_back(cs);
    pay.delete();
  endtask

  // Whole-frame reference: what a correct loader must do with the bytes in tx.
  task automatic expect_frame();
    logic [7:0]    cmd = tx[1];
    int            len = int'({tx[5], tx[4]});
    int            base = int'({tx[3], tx[2]});
    logic [7:0]    cs = 8'h00;
    logic [AW-1:0] a;
    if (cmd < 8'd1 || cmd > 8'd5) begin
      eq.push_back(ev(1, 0, 0, 2'd3)); n_send = 2; return;
    end
    if (cmd <= 8'd2) model_core = 1'b1;
    if (cmd >= 8'd3 && len != 0) begin
      eq.push_back(ev(1, 0, 0, 2'd3)); n_send = 6; return;
    end
    for (int i = 0; i < len; i++) begin
      a = AW'(base + i);
      wq.push_back({a, tx[6+i], cmd == 8'd1});
    end
    for (int i = 1; i < 6 + len; i++) cs ^= tx[i];
    n_send = 7 + len;
    if (cs == tx[6+len]) begin
      eq.push_back(ev(0, 1, cmd == 8'd5, 2'd0));
      if (cmd == 8'd3) model_core = 1'b0;
      if (cmd == 8'd4) model_core = 1'b1;
    end else eq.push_back(ev(1, 0, 0, 2'd1));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = ~bad_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame();
    for (int i = 0; i < n_send; i++) begin
      send_byte(tx[i], 1'b0);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
  endtask

  task automatic settle_check(input string name, input int wait_clks);
    repeat (wait_clks) @(negedge clk);
    chk({name, "_writes_left"}, wq.size(), 0);
    chk({name, "_events_left"}, eq.size(), 0);
    chk({name, "_core_reset"}, core_reset_o, model_core);
    chk({name, "_busy"}, busy_o, 0);
    wq.delete(); eq.delete();
  endtask

  task automatic run_frame(input string name, input logic [7:0] cmd, input logic [15:0] base,
                           input logic [15:0] len, input bit corrupt);
    make_frame(cmd, base, len, corrupt);
    expect_frame();
    send_frame();
    settle_check(name, 30);
  endtask

  int         r, l;
  logic [7:0] c;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_core_reset", core_reset_o, 1);
    chk("rst_debug", debug_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done_err_clr", {done_o, err_o, mem_clear_o}, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Frame 1: imem write of 11 22 33 at 0x010.
    dlog.delete();
    pay = '{8'h11, 8'h22, 8'h33};
    run_frame("f1", 8'h01, 16'h0010, 16'd3, 1'b0);
    chk("f1_nwrites", dlog.size(), 3);
    if (dlog.size() == 3) begin
      chk("f1_w0", dlog[0], {13'h010, 8'h11, 1'b1});
      chk("f1_w1", dlog[1], {13'h011, 8'h22, 1'b1});
      chk("f1_w2", dlog[2], {13'h012, 8'h33, 1'b1});
    end

    run_frame("run", 8'h03, 16'h0000, 16'd0, 1'b0);
    chk("run_core_low", core_reset_o, 0);
    run_frame("halt", 8'h04, 16'h0000, 16'd0, 1'b0);
    chk("halt_core_high", core_reset_o, 1);

    pay = '{8'h11, 8'h22, 8'h33};
    run_frame("f1_badcs", 8'h01, 16'h0010, 16'd3, 1'b1);
    run_frame("run_badcs", 8'h03, 16'h0000, 16'd0, 1'b1);
    chk("run_badcs_core", core_reset_o, 1);
    run_frame("clear", 8'h05, 16'h0000, 16'd0, 1'b0);

    // Address wrap in a 13-bit space.
    dlog.delete();
    pay = '{8'hAA, 8'hBB};
    run_frame("wrap", 8'h02, 16'h1FFF, 16'd2, 1'b0);
    chk("wrap_nwrites", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("wrap_w0", dlog[0], {13'h1FFF, 8'hAA, 1'b0});
      chk("wrap_w1", dlog[1], {13'h0000, 8'hBB, 1'b0});
    end

    // Timeout after A5 01.
    eq.push_back(ev(1, 0, 0, 2'd2));
    model_core = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    settle_check("timeout", TO + 60);

    // Bad stop bit: byte dropped, framing error, parser stays idle.
    eq.push_back(ev(1, 0, 0, 2'd0));
    send_byte(8'hA5, 1'b1);
    settle_check("badstop", 30);

    run_frame("badcmd", 8'h07, 16'h0000, 16'd0, 1'b0);
    run_frame("runlen", 8'h03, 16'h0000, 16'd2, 1'b0);

    // Reset mid-payload after the first data byte.
    wq.push_back({13'h010, 8'h11, 1'b1});
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy_o, 1);
    reset = 1'b0;
    #1;
    chk("midrst_core", core_reset_o, 1);
    chk("midrst_busy", busy_o, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    model_core = 1'b1;
    settle_check("midrst", 10);
    pay = '{8'h11, 8'h22, 8'h33};
    run_frame("after_rst", 8'h01, 16'h0010, 16'd3, 1'b0);

    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 11);
      l = 0;
      if (r <= 3)       begin c = 8'h01; l = $urandom_range(0, 5); end
      else if (r <= 6)  begin c = 8'h02; l = $urandom_range(0, 5); end
      else if (r == 7)  c = 8'h03;
      else if (r == 8)  c = 8'h04;
      else if (r == 9)  c = 8'h05;
      else if (r == 10) c = 8'($urandom_range(6, 255));
      else begin c = 8'(3 + $urandom_range(0, 2)); l = $urandom_range(1, 3); end
      run_frame("rand", c, 16'($urandom), 16'(l), $urandom_range(0, 4) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
